// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame sequencer.
package ws2812_pkg;
  localparam int GRB_W      = 24;
  localparam int DEF_T0H    = 20;
  localparam int DEF_T1H    = 40;
  localparam int DEF_TBIT   = 63;
  localparam int DEF_TRESET = 2500;

  typedef enum logic [1:0] {
    IDLE,
    PRELOAD,
    SEND,
    LATCH
  } state_e;
endpackage

// File: rtl/ws2812_bit_timer.sv
// Cycle counter: counts 0..terminal-1 while enabled, pulsing tc on the last count.
module ws2812_bit_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc    = enable && (cnt_q == terminal - W'(1));
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tc) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Streams NUM_LEDS GRB words from pixel RAM as WS2812 bit pulses, then holds the latch gap.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 3,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [GRB_W-1:0]  pix_data,
  output logic              dout
);
  localparam int TMAX  = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int BIT_W = $clog2(GRB_W);

  localparam logic [TW-1:0]     T0H_C    = TW'(T0H);
  localparam logic [TW-1:0]     T1H_C    = TW'(T1H);
  localparam logic [TW-1:0]     TBIT_C   = TW'(TBIT);
  localparam logic [TW-1:0]     TRESET_C = TW'(TRESET);
  localparam logic [TW-1:0]     TPRE_C   = TW'(2);
  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0]  MSB_IDX  = BIT_W'(GRB_W - 1);

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [ADDR_W-1:0]  led_q, led_d;
  logic [GRB_W-1:0]   shift_q, shift_d;
  logic [GRB_W-1:0]   next_q, next_d;
  logic               done_q, done_d;

  logic [TW-1:0]      tcnt;
  logic [TW-1:0]      tmr_term;
  logic               tmr_en;
  logic               tmr_clr;
  logic               tc;

  // Timer restarts on every state entry and whenever reset is applied.
  assign tmr_clr = rst || (state_d != state_q);

  ws2812_bit_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .clear    (tmr_clr),
    .enable   (tmr_en),
    .terminal (tmr_term),
    .count    (tcnt),
    .tc       (tc)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    led_d    = led_q;
    shift_d  = shift_q;
    next_d   = next_q;
    done_d   = 1'b0;
    pix_rd   = 1'b0;
    pix_addr = '0;
    tmr_en   = 1'b0;
    tmr_term = TBIT_C;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRELOAD;
          bit_d   = MSB_IDX;
          led_d   = '0;
        end
      end
      PRELOAD: begin
        tmr_en   = 1'b1;
        tmr_term = TPRE_C;
        pix_rd   = (tcnt == '0);
        if (tc) begin
          shift_d = pix_data;
          state_d = SEND;
        end
      end
      SEND: begin
        tmr_en = 1'b1;
        // Fetch the next LED's word during bit 0 so it is ready with no gap.
        if (bit_q == '0 && led_q != LAST_LED) begin
          if (tcnt == '0) begin
            pix_rd   = 1'b1;
            pix_addr = led_q + ADDR_W'(1);
          end
          if (tcnt == TW'(1)) begin
            next_d = pix_data;
          end
        end
        if (tc) begin
          if (bit_q == '0) begin
            if (led_q == LAST_LED) begin
              state_d = LATCH;
            end else begin
              led_d   = led_q + ADDR_W'(1);
              bit_d   = MSB_IDX;
              shift_d = next_q;
            end
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            shift_d = {shift_q[GRB_W-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        tmr_en   = 1'b1;
        tmr_term = TRESET_C;
        if (tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    next_q  <= next_d;
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dout = (state_q == SEND) && (tcnt < (shift_q[GRB_W-1] ? T1H_C : T0H_C));
endmodule
